// File: rtl/bit_scan_unit_pkg.sv
// Shared types and helpers for the bit scan unit: mode encoding, FSM state
// encoding and the result-width function.
package bit_scan_unit_pkg;

  typedef enum logic [1:0] {
    MODE_POPCNT = 2'b00,  // number of set bits
    MODE_RUN1   = 2'b01,  // longest run of ones
    MODE_RUN0   = 2'b10,  // longest run of zeros
    MODE_NRUNS  = 2'b11   // number of maximal runs of ones
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Result width: enough bits to hold the value WIDTH itself.
  function automatic int ow_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_scan_unit_if.sv
// Bus bundle between a word producer/result consumer and the bit scan unit.
//
// Handshake: a word moves when in_valid && in_ready are both high at a rising
// edge; a result moves when out_valid && out_ready are both high at a rising
// edge. out_valid/op stay stable until taken. dbg_state mirrors the FSM.
interface bit_scan_unit_if #(
  parameter int WIDTH = 16,
  parameter int OW    = 5
);
  logic [WIDTH-1:0] i;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [OW-1:0]    op;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output i, mode, in_valid, out_ready,
    input  in_ready, op, out_valid, busy, dbg_state
  );

  modport slave (
    input  i, mode, in_valid, out_ready,
    output in_ready, op, out_valid, busy, dbg_state
  );
endinterface

// File: rtl/bit_scan_unit_chunk.sv
// Combinational step of the scan: folds one BPC-bit chunk (LSB first) into
// the accumulator / current-run / previous-bit state.
module bit_scan_chunk
  import bit_scan_unit_pkg::*;
#(
  parameter int BPC = 1,
  parameter int OW  = 5
) (
  input  logic [BPC-1:0] i_chunk,
  input  mode_e          i_mode,
  input  logic [OW-1:0]  i_acc,
  input  logic [OW-1:0]  i_run,
  input  logic           i_prev,
  output logic [OW-1:0]  o_acc,
  output logic [OW-1:0]  o_run,
  output logic           o_prev
);

  logic [OW-1:0] w_acc;
  logic [OW-1:0] w_run;
  logic          w_prev;

  // Walk the chunk bit by bit; the running max is refreshed on every bit so a
  // run that reaches the top bit is already accounted for.
  always_comb begin
    w_acc  = i_acc;
    w_run  = i_run;
    w_prev = i_prev;
    for (int b = 0; b < BPC; b++) begin
      case (i_mode)
        MODE_POPCNT: begin
          if (i_chunk[b]) w_acc = w_acc + OW'(1);
        end
        MODE_RUN1, MODE_RUN0: begin
          if (i_chunk[b] == (i_mode == MODE_RUN1)) begin
            w_run = w_run + OW'(1);
            if (w_run > w_acc) w_acc = w_run;
          end else begin
            w_run = '0;
          end
        end
        MODE_NRUNS: begin
          if (i_chunk[b] && !w_prev) w_acc = w_acc + OW'(1);
        end
        default: begin
        end
      endcase
      w_prev = i_chunk[b];
    end
  end

  assign o_acc  = w_acc;
  assign o_run  = w_run;
  assign o_prev = w_prev;

endmodule

// File: rtl/bit_scan_unit.sv
// Multi-cycle bit scanner: captures a word, scans BPC bits per cycle and
// presents one of popcount / longest-1-run / longest-0-run / run count.
module bit_scan_unit
  import bit_scan_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input logic             clk,
  input logic             reset,
  bit_scan_unit_if.slave  bus
);

  localparam int OW  = ow_width(WIDTH);
  localparam int NCH = WIDTH / BPC;
  localparam int CW  = $clog2(NCH + 1);

  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] SCAN = S_SCAN;
  localparam logic [1:0] DONE = S_DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_word;
  mode_e            r_mode;
  logic [CW-1:0]    r_cnt;
  logic [OW-1:0]    r_acc;
  logic [OW-1:0]    r_run;
  logic             r_prev;
  logic [OW-1:0]    r_op;

  logic [OW-1:0]    w_acc;
  logic [OW-1:0]    w_run;
  logic             w_prev;

  bit_scan_chunk #(
    .BPC (BPC),
    .OW  (OW)
  ) u_chunk (
    .i_chunk (r_word[BPC-1:0]),
    .i_mode  (r_mode),
    .i_acc   (r_acc),
    .i_run   (r_run),
    .i_prev  (r_prev),
    .o_acc   (w_acc),
    .o_run   (w_run),
    .o_prev  (w_prev)
  );

  // FSM plus scan datapath; the word is shifted right so the next chunk is
  // always in the low bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_mode  <= MODE_POPCNT;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_run   <= '0;
      r_prev  <= 1'b0;
      r_op    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_word  <= bus.i;
            r_mode  <= mode_e'(bus.mode);
            r_cnt   <= '0;
            r_acc   <= '0;
            r_run   <= '0;
            r_prev  <= 1'b0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          r_word <= r_word >> BPC;
          r_acc  <= w_acc;
          r_run  <= w_run;
          r_prev <= w_prev;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(NCH - 1)) begin
            r_op    <= w_acc;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state == SCAN);
  assign bus.out_valid = (r_state == DONE);
  assign bus.op        = r_op;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_bit_scan_unit.sv
// Bench for bit_scan_unit: one instance scanning 1 bit/cycle, one 4 bits/cycle.
module tb_bit_scan_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;

  bit_scan_unit_if #(.WIDTH(16), .OW(5)) bus16 ();
  bit_scan_unit_if #(.WIDTH(16), .OW(5)) bus4 ();

  bit_scan_unit #(.WIDTH(16), .BPC(1)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  bit_scan_unit #(.WIDTH(16), .BPC(4)) dut4  (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  // Reference: independent bit-position formulation of each mode.
  function automatic logic [4:0] model(input logic [15:0] w, input logic [1:0] m);
    int res;
    int len;
    logic tgt;
    res = 0;
    case (m)
      2'b00: for (int k = 0; k < 16; k++) res += int'(w[k]);
      2'b01, 2'b10: begin
        tgt = (m == 2'b01);
        for (int s = 0; s < 16; s++) begin
          len = 0;
          while (s + len < 16 && w[s+len] == tgt) len++;
          if (len > res) res = len;
        end
      end
      default: for (int k = 0; k < 16; k++)
        if (w[k] && (k == 0 || !w[k-1])) res++;
    endcase
    return 5'(res);
  endfunction

  task automatic drive(input bit sel, input logic [15:0] w, input logic [1:0] m, input logic v);
    if (sel) begin bus4.i = w; bus4.mode = m; bus4.in_valid = v; end
    else begin bus16.i = w; bus16.mode = m; bus16.in_valid = v; end
  endtask

  function automatic logic [4:0] rd_op(input bit sel);  return sel ? bus4.op : bus16.op; endfunction
  function automatic logic rd_ov(input bit sel);        return sel ? bus4.out_valid : bus16.out_valid; endfunction
  function automatic logic rd_ir(input bit sel);        return sel ? bus4.in_ready : bus16.in_ready; endfunction
  function automatic logic rd_busy(input bit sel);      return sel ? bus4.busy : bus16.busy; endfunction

  // One full transaction with out_ready high; garbage is driven on the inputs
  // during the scan and must not disturb it.
  task automatic do_word(input bit sel, input logic [15:0] w, input logic [1:0] m,
                         input logic [4:0] exp, input int lat, input string tag);
    int n;
    logic ov;
    logic [4:0] e;
    @(negedge clk);
    drive(sel, w, m, 1'b1);
    @(posedge clk);
    exp_q.push_back(exp);
    #1 drive(sel, ~w, ~m, 1'b1);
    n = 0;
    ov = 1'b0;
    while (!ov && n < lat + 8) begin
      @(posedge clk);
      #1;
      n++;
      ov = rd_ov(sel);
      if (n == 1) begin
        n_checks++;
        if (rd_busy(sel) !== 1'b1) $display("FAIL %s busy: got %b want 1", tag, rd_busy(sel));
        else n_pass++;
      end
      if (n >= lat - 1) drive(sel, ~w, ~m, 1'b0);
    end
    n_checks++;
    if (ov !== 1'b1 || n != lat) $display("FAIL %s latency: got %0d (valid %b) want %0d", tag, n, ov, lat);
    else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1f;
    n_checks++;
    if (rd_op(sel) !== e) $display("FAIL %s op: got %0d want %0d", tag, rd_op(sel), e);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (rd_ir(sel) !== 1'b1 || rd_ov(sel) !== 1'b0)
      $display("FAIL %s return_idle: in_ready=%b out_valid=%b want 1/0", tag, rd_ir(sel), rd_ov(sel));
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (rd_ir(s[0]) !== 1'b1 || rd_ov(s[0]) !== 1'b0 || rd_busy(s[0]) !== 1'b0 || rd_op(s[0]) !== 5'd0)
        $display("FAIL reset_state[%0d]: ir=%b ov=%b busy=%b op=%0d want 1/0/0/0",
                 s, rd_ir(s[0]), rd_ov(s[0]), rd_busy(s[0]), rd_op(s[0]));
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_modes(input bit sel, input int lat);
    logic [15:0] words [4] = '{16'h0000, 16'hFFFF, 16'h71C7, 16'hAAAA};
    logic [4:0]  expv  [4][4] = '{'{5'd0, 5'd0, 5'd16, 5'd0},
                                  '{5'd16, 5'd16, 5'd0, 5'd1},
                                  '{5'd9, 5'd3, 5'd3, 5'd3},
                                  '{5'd8, 5'd1, 5'd1, 5'd8}};
    for (int wi = 0; wi < 4; wi++)
      for (int m = 0; m < 4; m++)
        if (!(sel && wi == 0))
          do_word(sel, words[wi], 2'(m), expv[wi][m], lat, $sformatf("modes_b%0d_%h_m%0d", sel ? 4 : 1, words[wi], m));
  endtask

  task automatic test_backpressure();
    int n;
    logic [4:0] e;
    bus16.out_ready = 1'b0;
    @(negedge clk);
    drive(1'b0, 16'hFC7E, 2'b01, 1'b1);
    @(posedge clk);
    exp_q.push_back(5'd6);
    #1 drive(1'b0, 16'h0000, 2'b00, 1'b0);
    n = 0;
    while (bus16.out_valid !== 1'b1 && n < 24) begin
      @(posedge clk);
      #1 n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1f;
    drive(1'b0, 16'h1234, 2'b00, 1'b1);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus16.out_valid !== 1'b1 || bus16.op !== e || bus16.in_ready !== 1'b0)
        $display("FAIL hold_cycle%0d: ov=%b op=%0d ir=%b want 1/%0d/0", c, bus16.out_valid, bus16.op, bus16.in_ready, e);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus16.dbg_state !== 2'd0 || bus16.out_valid !== 1'b0 || bus16.op !== e)
      $display("FAIL release_idle: state=%0d ov=%b op=%0d want 0/0/%0d", bus16.dbg_state, bus16.out_valid, bus16.op, e);
    else n_pass++;
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic seen;
    @(negedge clk);
    drive(1'b0, 16'hFFFF, 2'b00, 1'b1);
    @(posedge clk);
    #1 drive(1'b0, 16'h0000, 2'b00, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus16.op !== 5'd0 || bus16.out_valid !== 1'b0 || bus16.busy !== 1'b0 || bus16.in_ready !== 1'b1)
      $display("FAIL mid_reset_state: op=%0d ov=%b busy=%b ir=%b want 0/0/0/1",
               bus16.op, bus16.out_valid, bus16.busy, bus16.in_ready);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (bus16.out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL mid_reset_no_valid: got %b want 0", seen);
    else n_pass++;
    do_word(1'b0, 16'h0010, 2'b00, 5'd1, 16, "post_reset");
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic [1:0] m;
    for (int k = 0; k < 6; k++) begin
      w = 16'($urandom_range(0, 65535));
      m = 2'($urandom_range(0, 3));
      do_word(1'b0, w, m, model(w, m), 16, $sformatf("rand_b1_%h_m%0d", w, m));
      do_word(1'b1, w, m, model(w, m), 4, $sformatf("rand_b4_%h_m%0d", w, m));
    end
  endtask

  initial begin
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
    drive(1'b1, 16'h0000, 2'b00, 1'b0);
    bus16.out_ready = 1'b1;
    bus4.out_ready  = 1'b1;
    test_reset();
    test_modes(1'b0, 16);
    test_modes(1'b1, 4);
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_scan_unit.md
BIT_SCAN_UNIT -- requirements
Module: bit_scan_unit

Interface
REQ-001 Parameter WIDTH, default 16, input word width in bits; SHALL be >= 2.
REQ-002 Parameter BPC, default 1, bits scanned per cycle; SHALL divide WIDTH exactly.
REQ-003 Derived constant OW = clog2(WIDTH+1), the result width (5 for WIDTH=16).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 i  in  WIDTH  input word.
REQ-007 mode  in  2  operation: 00 popcount, 01 longest run of ones, 10 longest run of zeros, 11 number of runs of ones.
REQ-008 in_valid  in  1  i and mode are valid.
REQ-009 in_ready  out  1  block accepts a word.
REQ-010 op  out  OW  result.
REQ-011 out_valid  out  1  op holds a completed result.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 busy  out  1  a scan is in progress.

Function
REQ-014 FSM states IDLE, SCAN, DONE; in_ready SHALL be 1 only in IDLE, busy 1 only in SCAN, out_valid 1 only in DONE.
REQ-015 IDLE with in_valid=1 at a rising edge SHALL capture i and mode into internal registers and enter SCAN; otherwise stay IDLE.
REQ-016 SCAN SHALL consume BPC bits per cycle, LSB first, for exactly WIDTH/BPC cycles, then enter DONE with op updated on the same edge.
REQ-017 Latency: capture at edge k -> out_valid high immediately after edge k+WIDTH/BPC (16 cycles at defaults).
REQ-018 Changes on i, mode or in_valid SHALL have no effect outside IDLE.
REQ-019 DONE SHALL hold op and out_valid stable until an edge with out_ready=1, then return to IDLE; no new word is accepted in that same cycle.
REQ-020 Run tracking SHALL carry the current run length across chunk boundaries; a run ending at bit WIDTH-1 SHALL be counted.
REQ-021 Results SHALL saturate-free fit OW bits: all-ones gives WIDTH for modes 00/01, all-zeros gives WIDTH for mode 10.
REQ-022 Mode 11 SHALL count maximal groups of contiguous ones; all-zeros -> 0, all-ones -> 1.
REQ-023 op SHALL change only on the SCAN->DONE edge or under reset; it retains its value in IDLE.

Reset
REQ-024 reset=0 at a rising edge SHALL force IDLE, op=0, out_valid=0, busy=0, in_ready=1 on the following cycle, clearing all scan counters and run registers.
REQ-025 Reset asserted mid-SCAN or in DONE SHALL abandon the word; no out_valid pulse follows.
REQ-026 Reset SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-027 A shared package SHALL hold the mode encoding enum, the FSM state enum and the OW width function.
REQ-028 One sub-module, bit_scan_chunk, SHALL be combinational: takes a BPC-bit chunk, mode and current accumulator/run/previous-bit state, returns next state; bit_scan_unit instantiates it once.
REQ-029 Scan cycle counter width SHALL be clog2(WIDTH/BPC+1); no other multi-cycle datapath.

Verification
REQ-030 Defaults, i=0x0000 each mode, out_ready=1 -> op=0,0,16,0; out_valid exactly 16 cycles after capture.
REQ-031 i=0xFFFF -> mode 00 op=16, 01 op=16, 10 op=0, 11 op=1.
REQ-032 i=0x71C7 -> mode 00 op=9, 01 op=3, 10 op=3, 11 op=3; i=0xAAAA mode 11 -> op=8, mode 01 -> op=1.
REQ-033 i=0xFC7E, mode 01, out_ready held 0 for 5 cycles -> op=6 stable, out_valid high all 5 cycles, in_ready low; IDLE one cycle after out_ready=1.
REQ-034 reset=0 on 8th SCAN cycle of 0xFFFF -> op=0, out_valid never asserts, next word 0x0010 mode 00 -> op=1.
REQ-035 Rerun REQ-031/032 with WIDTH=16, BPC=4 -> identical op values, latency 4 cycles.
